// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: LSB-first bits captured on en_cun strobes after a start pulse,
// word presented on data_out with a valid/ack handshake. Define PARITY_CHECK_EN for an even-parity trailer bit.
module shift_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             en_cun,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ack,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_srNext;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_commitWord;
    logic [CW-1:0]    r_bitCnt;
    logic [CW-1:0]    w_bitCntNext;
    logic             w_commit;
    logic [WIDTH-1:0] r_dataOut;
    logic             r_dataValid;
    logic             r_overrun;

    assign w_shifted = {data_in, r_sr[WIDTH-1:1]};

    // start always wins over a same-cycle strobe, in every non-IDLE state as well as IDLE
    always_comb begin
        w_nextState  = r_state;
        w_srNext     = r_sr;
        w_bitCntNext = r_bitCnt;
        w_commit     = 1'b0;
        w_commitWord = w_shifted;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState  = SHIFT;
                    w_srNext     = '0;
                    w_bitCntNext = '0;
                end
            end
            SHIFT: begin
                if (start) begin
                    w_srNext     = '0;
                    w_bitCntNext = '0;
                end else if (en_cun) begin
                    w_srNext     = w_shifted;
                    w_bitCntNext = r_bitCnt + CW'(1);
                    if (r_bitCnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        w_nextState = PARITY;
`else
                        w_nextState = IDLE;
                        w_commit    = 1'b1;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (start) begin
                    w_nextState  = SHIFT;
                    w_srNext     = '0;
                    w_bitCntNext = '0;
                end else if (en_cun) begin
                    w_nextState  = IDLE;
                    w_commit     = 1'b1;
                    w_commitWord = r_sr;
                end
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_bitCnt <= '0;
        end else begin
            r_state  <= w_nextState;
            r_sr     <= w_srNext;
            r_bitCnt <= w_bitCntNext;
        end
    end

    // A commit that coincides with an ack simply replaces the word; only an unacked word being overwritten is an overrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (w_commit) begin
            r_dataOut   <= w_commitWord;
            r_dataValid <= 1'b1;
            if (r_dataValid && !data_ack) begin
                r_overrun <= 1'b1;
            end
        end else if (r_dataValid && data_ack) begin
            r_dataValid <= 1'b0;
        end
    end

`ifdef PARITY_CHECK_EN
    logic r_parityErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parityErr <= 1'b0;
        end else if (w_commit) begin
            r_parityErr <= ^{r_sr, data_in};
        end
    end

    assign parity_err = r_parityErr;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = r_dataOut;
    assign data_valid = r_dataValid;
    assign overrun    = r_overrun;
    assign busy       = (r_state != IDLE);

endmodule
